// File: rtl/seg7_scan_decoder_if.sv
// Display-bus and decoded-result bundle for seg7_scan_decoder: the scanner
// side drives seg_n/dig_n/clr, the decoder returns the published digit state.
interface seg7_scan_decoder_if #(
    parameter int NDIG = 4
);
    logic [7:0]        seg_n;
    logic [NDIG-1:0]   dig_n;
    logic              clr;
    logic [4*NDIG-1:0] hex_o;
    logic [NDIG-1:0]   dp_o;
    logic [NDIG-1:0]   vld_o;
    logic [NDIG-1:0]   upd_o;
    logic [NDIG-1:0]   bad_o;
    logic              sel_err_o;

    modport master (
        output seg_n, dig_n, clr,
        input  hex_o, dp_o, vld_o, upd_o, bad_o, sel_err_o
    );

    modport slave (
        input  seg_n, dig_n, clr,
        output hex_o, dp_o, vld_o, upd_o, bad_o, sel_err_o
    );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Samples a multiplexed active-low 7-segment bus once per scan window and
// publishes per-digit hex/dp after STABLE matching visits. SEG7_DEC_BLANK_EN adds blank (7F) samples.
module seg7_scan_decoder #(
    parameter int NDIG   = 4,
    parameter int SETTLE = 2,
    parameter int STABLE = 3
) (
    input logic                clk,
    input logic                rst,
    seg7_scan_decoder_if.slave bus
);
    typedef struct packed {
        logic       known;
        logic       blank;
        logic [3:0] val;
    } dec_t;

    typedef struct packed {
        logic       blank;
        logic       dp;
        logic [3:0] val;
    } sample_t;

    function automatic dec_t decode(input logic [6:0] pat);
        dec_t d;
        d = '{known: 1'b1, blank: 1'b0, val: 4'h0};
        case (pat)
            7'h40: d.val = 4'h0;
            7'h79: d.val = 4'h1;
            7'h24: d.val = 4'h2;
            7'h30: d.val = 4'h3;
            7'h19: d.val = 4'h4;
            7'h12: d.val = 4'h5;
            7'h02: d.val = 4'h6;
            7'h78: d.val = 4'h7;
            7'h00: d.val = 4'h8;
            7'h18: d.val = 4'h9;
            7'h08: d.val = 4'hA;
            7'h03: d.val = 4'hB;
            7'h46: d.val = 4'hC;
            7'h21: d.val = 4'hD;
            7'h06: d.val = 4'hE;
            7'h0E: d.val = 4'hF;
`ifdef SEG7_DEC_BLANK_EN
            7'h7F: d.blank = 1'b1;
`endif
            default: d.known = 1'b0;
        endcase
        return d;
    endfunction

    logic [NDIG-1:0] sel_q;
    logic [3:0]      run;
    sample_t         cand [NDIG];
    logic [3:0]      mcnt [NDIG];

    dec_t            dec;
    sample_t         samp;
    logic [NDIG-1:0] sel;
    logic            sample_pt;
    logic            single_sel;
    logic            multi_sel;
    logic [NDIG-1:0] bad_set;
    logic [NDIG-1:0] pub;

    // NOTE: every always_comb output gets a value on every path, so no latch can be inferred.
    always_comb begin
        dec        = decode(bus.seg_n[6:0]);
        samp       = '{blank: dec.blank, dp: ~bus.seg_n[7], val: dec.val};
        sel        = ~bus.dig_n;
        sample_pt  = (bus.dig_n == sel_q) && (run == 4'(SETTLE - 1));
        single_sel = sample_pt && $onehot(sel);
        multi_sel  = sample_pt && ($countones(sel) > 1);
        bad_set    = (single_sel && !dec.known) ? sel : '0;
        pub        = '0;
        for (int d = 0; d < NDIG; d++) begin
            // A blank candidate only matters while the digit still shows a value.
            if (mcnt[d] == 4'(STABLE))
                pub[d] = cand[d].blank ? bus.vld_o[d]
                       : (!bus.vld_o[d] || cand[d].val != bus.hex_o[4*d +: 4] ||
                          cand[d].dp != bus.dp_o[d]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: candidate/match arrays are per-digit registers, not RAM, so they take the synchronous reset.
            sel_q         <= '1;
            run           <= '0;
            bus.hex_o     <= '0;
            bus.dp_o      <= '0;
            bus.vld_o     <= '0;
            bus.upd_o     <= '0;
            bus.bad_o     <= '0;
            bus.sel_err_o <= 1'b0;
            for (int d = 0; d < NDIG; d++) begin
                cand[d] <= '0;
                mcnt[d] <= '0;
            end
        end else begin
            sel_q <= bus.dig_n;
            if (bus.dig_n != sel_q)
                run <= '0;
            else if (run != 4'(SETTLE))
                run <= run + 4'd1;

            // A new error event outranks a coincident clear.
            bus.sel_err_o <= (bus.sel_err_o && !bus.clr) || multi_sel;
            bus.bad_o     <= (bus.clr ? '0 : bus.bad_o) | bad_set;
            bus.upd_o     <= pub;

            for (int d = 0; d < NDIG; d++) begin
                if (single_sel && sel[d]) begin
                    if (!dec.known) begin
                        mcnt[d] <= '0;
                    end else if (samp == cand[d]) begin
                        if (mcnt[d] != 4'(STABLE))
                            mcnt[d] <= mcnt[d] + 4'd1;
                    end else begin
                        cand[d] <= samp;
                        mcnt[d] <= 4'd1;
                    end
                end
                if (pub[d]) begin
                    bus.vld_o[d]         <= ~cand[d].blank;
                    bus.hex_o[4*d +: 4]  <= cand[d].blank ? 4'h0 : cand[d].val;
                    bus.dp_o[d]          <= ~cand[d].blank & cand[d].dp;
                end
            end
        end
    end
endmodule
